alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter IMM_W, default 8, immediate width; SHALL satisfy IMM_W <= WIDTH.
REQ-003 i_clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 i_rst  in  1  reset; synchronous, active-high.
REQ-005 i_valid  in  1  operation request.
REQ-006 o_ready  out  1  block can accept; an operation is accepted on an edge where i_valid && o_ready.
REQ-007 i_aluop  in  5  [4:1] opcode, [0] mode bit (lsb).
REQ-008 i_dataA, i_dataB  in  WIDTH  operands.
REQ-009 i_imm  in  IMM_W  immediate.
REQ-010 o_valid  out  1  one-cycle result strobe.
REQ-011 o_dataResult  out  WIDTH  result; holds last value between strobes.
REQ-012 o_shldBranch  out  1  branch decision, meaningful only while o_valid=1, else 0.
REQ-013 o_flags  out  4  {V,C,N,Z}; held between strobes.

Function
REQ-014 Operands, opcode, lsb and imm SHALL be registered at acceptance; later input changes SHALL not affect the operation.
REQ-015 FSM states IDLE, MUL, DIV; o_ready SHALL equal (state==IDLE).
REQ-016 Single-cycle ops SHALL stay in IDLE; o_valid SHALL assert on the edge after acceptance (latency 1); back-to-back acceptance every cycle SHALL be supported.
REQ-017 Opcode 0 ADD / 1 SUB: A+B / A-B modulo 2^WIDTH; C = carry-out (ADD) or borrow (SUB); V = signed overflow when lsb=1, else 0.
REQ-018 Opcodes 2 OR, 3 AND, 4 XOR, 5 NOT(~A): bitwise; C=V=0.
REQ-019 Opcodes 6, 7: result = A (address pass-through); C=V=0.
REQ-020 Opcode 8 LOAD: lsb=0 -> zero-extended imm; lsb=1 -> imm in bits [WIDTH-1:WIDTH-IMM_W], rest 0.
REQ-021 Opcode 9 CMP: result bit0 A==B, bit1 A==0, bit2 B==0, bit3 A>B, bit4 A<B, upper bits 0; signed compare when lsb=1; flags SHALL NOT update.
REQ-022 Opcodes 10 SHL / 11 SHR: A shifted logically by B[$clog2(WIDTH)-1:0]; C=V=0.
REQ-023 Opcode 12 JMPA: result = lsb ? A : zero-extended imm; o_shldBranch=1.
REQ-024 Opcode 13 JMPR: result = A; o_shldBranch = B[{lsb, imm[1:0]}]; flags unchanged.
REQ-025 Opcode 14 MUL (unsigned, shift-add, one bit per cycle): state MUL for exactly WIDTH cycles, then IDLE with o_valid; result = lsb ? high half : low half of 2*WIDTH product.
REQ-026 Opcode 15 DIV (unsigned restoring, one bit per cycle): state DIV for exactly WIDTH cycles; result = lsb ? remainder : quotient.
REQ-027 DIV with B==0: quotient all ones, remainder = A, V=1; same latency.
REQ-028 Multi-cycle latency SHALL be WIDTH+1 edges from acceptance to o_valid; o_ready SHALL be high in the o_valid cycle.
REQ-029 i_valid while o_ready=0 SHALL be ignored (no queuing).
REQ-030 Z = (result==0), N = result[WIDTH-1], updated only in the o_valid cycle except CMP/JMPR; MUL/DIV set C=0, V=0 unless REQ-027.

Reset
REQ-031 While i_rst=1 at an edge: state IDLE, o_valid=0, o_shldBranch=0, o_dataResult=0, o_flags=0, o_ready=1 after that edge.
REQ-032 Reset during MUL/DIV SHALL abort the operation with no o_valid; reset SHALL override simultaneous acceptance.

Verification (WIDTH=16, IMM_W=8)
REQ-033 ADD lsb=1, A=0x7FFF, B=0x0001 -> next cycle o_valid=1, result 0x8000, flags V=1,C=0,N=1,Z=0.
REQ-034 MUL A=0x1234, B=0x0010, lsb=0 -> o_ready low 16 cycles, o_valid on edge 17, result 0x2340; lsb=1 -> 0x0001.
REQ-035 DIV A=100, B=7 -> quotient 0x000E (lsb=0), remainder 0x0002 (lsb=1); A=0x1234, B=0 -> 0xFFFF, V=1.
REQ-036 Reset asserted on 5th MUL cycle -> no o_valid ever for that op, o_ready=1 and all outputs 0 after reset edge.
REQ-037 JMPR lsb=1, imm=0x01, B=0x0020, A=0x00AB -> o_shldBranch=1, result 0x00AB; B=0x0000 -> o_shldBranch=0.
REQ-038 ADD then SUB (A=5,B=3) on consecutive edges -> o_valid two consecutive cycles, results 0x0008 then 0x0002; i_valid during MUL busy -> not accepted.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: most opcodes finish one edge after acceptance; MUL and DIV are
// iterative, one bit per clock. All outputs are registered and held between strobes.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [4:0]         i_aluop,
  input  logic [WIDTH-1:0]   i_dataA,
  input  logic [WIDTH-1:0]   i_dataB,
  input  logic [IMM_W-1:0]   i_imm,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_dataResult,
  output logic               o_shldBranch,
  output logic [3:0]         o_flags
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W-1:0] LAST_STEP = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [3:0]        op_reg;
  logic              lsb_reg;
  logic [IMM_W-1:0]  imm_reg;
  logic              pend_reg;
  logic [SH_W-1:0]   cnt_reg;
  // Shared iteration registers: product high half / remainder, multiplier / quotient
  logic [WIDTH-1:0]  hi_reg, lo_reg;

  logic              valid_reg, branch_reg;
  logic [WIDTH-1:0]  result_reg;
  logic [3:0]        flags_reg;

  logic [WIDTH:0]    sum_next, dif_next;
  logic [WIDTH-1:0]  alu_res_next;
  logic              alu_c_next, alu_v_next, alu_br_next, alu_keep_next;
  logic              cmp_gt_next, cmp_lt_next;

  logic [WIDTH:0]    mul_sum_next;
  logic [WIDTH-1:0]  mul_hi_next, mul_lo_next, mul_res_next;
  logic [WIDTH:0]    rem_sh_next;
  logic              fits_next;
  logic [WIDTH-1:0]  rem_next, quo_next, div_res_next;

  assign o_ready      = (state_reg == IDLE);
  assign o_valid      = valid_reg;
  assign o_dataResult = result_reg;
  assign o_shldBranch = branch_reg;
  assign o_flags      = flags_reg;

  always_comb begin
    sum_next      = {1'b0, a_reg} + {1'b0, b_reg};
    dif_next      = {1'b0, a_reg} - {1'b0, b_reg};
    cmp_gt_next   = lsb_reg ? ($signed(a_reg) > $signed(b_reg)) : (a_reg > b_reg);
    cmp_lt_next   = lsb_reg ? ($signed(a_reg) < $signed(b_reg)) : (a_reg < b_reg);
    alu_res_next  = a_reg;
    alu_c_next    = 1'b0;
    alu_v_next    = 1'b0;
    alu_br_next   = 1'b0;
    alu_keep_next = 1'b0;
    case (op_reg)
      4'd0: begin
        alu_res_next = sum_next[WIDTH-1:0];
        alu_c_next   = sum_next[WIDTH];
        alu_v_next   = lsb_reg && (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                       && (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'd1: begin
        alu_res_next = dif_next[WIDTH-1:0];
        alu_c_next   = dif_next[WIDTH];
        alu_v_next   = lsb_reg && (a_reg[WIDTH-1] != b_reg[WIDTH-1])
                       && (dif_next[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'd2:  alu_res_next = a_reg | b_reg;
      4'd3:  alu_res_next = a_reg & b_reg;
      4'd4:  alu_res_next = a_reg ^ b_reg;
      4'd5:  alu_res_next = ~a_reg;
      4'd8:  alu_res_next = lsb_reg ? (WIDTH'(imm_reg) << (WIDTH - IMM_W)) : WIDTH'(imm_reg);
      4'd9: begin
        alu_res_next      = '0;
        alu_res_next[4:0] = {cmp_lt_next, cmp_gt_next, (b_reg == '0), (a_reg == '0), (a_reg == b_reg)};
        alu_keep_next     = 1'b1;
      end
      4'd10: alu_res_next = a_reg << b_reg[SH_W-1:0];
      4'd11: alu_res_next = a_reg >> b_reg[SH_W-1:0];
      4'd12: begin
        alu_res_next = lsb_reg ? a_reg : WIDTH'(imm_reg);
        alu_br_next  = 1'b1;
      end
      4'd13: begin
        alu_br_next   = b_reg[{lsb_reg, imm_reg[1:0]}];
        alu_keep_next = 1'b1;
      end
      default: alu_res_next = a_reg;
    endcase
  end

  // One shift-add step and one restoring-divide step per clock
  always_comb begin
    mul_sum_next = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    mul_hi_next  = mul_sum_next[WIDTH:1];
    mul_lo_next  = {mul_sum_next[0], lo_reg[WIDTH-1:1]};
    mul_res_next = lsb_reg ? mul_hi_next : mul_lo_next;
    rem_sh_next  = {hi_reg, lo_reg[WIDTH-1]};
    fits_next    = (rem_sh_next >= {1'b0, b_reg});
    rem_next     = fits_next ? WIDTH'(rem_sh_next - {1'b0, b_reg}) : rem_sh_next[WIDTH-1:0];
    quo_next     = {lo_reg[WIDTH-2:0], fits_next};
    div_res_next = lsb_reg ? rem_next : quo_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      lsb_reg    <= 1'b0;
      imm_reg    <= '0;
      pend_reg   <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      valid_reg  <= 1'b0;
      branch_reg <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      valid_reg  <= 1'b0;
      branch_reg <= 1'b0;
      pend_reg   <= 1'b0;
      if (pend_reg) begin
        valid_reg  <= 1'b1;
        result_reg <= alu_res_next;
        branch_reg <= alu_br_next;
        if (!alu_keep_next)
          flags_reg <= {alu_v_next, alu_c_next, alu_res_next[WIDTH-1], (alu_res_next == '0)};
      end
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_reg   <= i_dataA;
            b_reg   <= i_dataB;
            op_reg  <= i_aluop[4:1];
            lsb_reg <= i_aluop[0];
            imm_reg <= i_imm;
            cnt_reg <= '0;
            if (i_aluop[4:1] == 4'd14) begin
              state_reg <= MUL;
              hi_reg    <= '0;
              lo_reg    <= i_dataB;
            end else if (i_aluop[4:1] == 4'd15) begin
              state_reg <= DIV;
              hi_reg    <= '0;
              lo_reg    <= i_dataA;
            end else begin
              pend_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          hi_reg  <= mul_hi_next;
          lo_reg  <= mul_lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg  <= IDLE;
            valid_reg  <= 1'b1;
            result_reg <= mul_res_next;
            flags_reg  <= {2'b00, mul_res_next[WIDTH-1], (mul_res_next == '0)};
          end
        end
        DIV: begin
          hi_reg  <= rem_next;
          lo_reg  <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg  <= IDLE;
            valid_reg  <= 1'b1;
            result_reg <= div_res_next;
            flags_reg  <= {(b_reg == '0), 1'b0, div_res_next[WIDTH-1], (div_res_next == '0)};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
